// File: rtl/mini_aes_mixcol_pkg.sv
// Shared types and constants for the Mini-AES MixColumns engine.
// GF(2^4) arithmetic uses the reduction polynomial x^4+x+1.
package mini_aes_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mixcol_state_e;

  localparam nibble_t    MIX_DIAG = 4'h3;
  localparam nibble_t    MIX_OFF  = 4'h2;
  localparam logic [4:0] GF_POLY  = 5'b10011;

  // Multiply by x, folding the overflow term back in with the low bits of the polynomial.
  function automatic nibble_t gf_xtime(input nibble_t v);
    gf_xtime = {v[2:0], 1'b0} ^ (v[3] ? GF_POLY[3:0] : 4'h0);
  endfunction

endpackage

// File: rtl/mini_aes_mixcol_if.sv
// Valid/ready stream carrying one 16-bit Mini-AES state.
interface mini_aes_mixcol_if;
  logic        valid;
  logic        ready;
  logic [15:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mini_aes_mixcol_gf16_mul.sv
// Combinational GF(2^4) multiplier, z = a * b mod x^4+x+1.
module gf16_mul
  import mini_aes_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  output nibble_t z
);

  nibble_t acc_s;
  nibble_t sh_s;

  // Shift-and-add: accumulate a*x^i for every set bit of b.
  always_comb begin
    acc_s = 4'h0;
    sh_s  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        acc_s = acc_s ^ sh_s;
      end else begin
        acc_s = acc_s;
      end
      sh_s = gf_xtime(sh_s);
    end
  end

  assign z = acc_s;

endmodule

// File: rtl/mini_aes_mixcol.sv
// Serial 2x2 MixColumns over GF(2^4): one result nibble per cycle from a
// single pair of multipliers, handed downstream over valid/ready.
module mini_aes_mixcol
  import mini_aes_pkg::*;
#(
  parameter nibble_t COEF_DIAG = MIX_DIAG,
  parameter nibble_t COEF_OFF  = MIX_OFF
) (
  input  logic                     clk,
  input  logic                     n_rst,
  mini_aes_mixcol_if.slave         in_if,
  mini_aes_mixcol_if.master        out_if,
  output logic                     busy
);

  mixcol_state_e state_r;
  mixcol_state_e state_next_s;
  logic [1:0]    cnt_r;
  nibble_t       opnd_r [4];
  nibble_t       res_r  [4];
  logic          out_valid_r;
  logic          accept_s;
  nibble_t       x_s;
  nibble_t       y_s;
  nibble_t       prod_diag_s;
  nibble_t       prod_off_s;
  nibble_t       b_s;

  assign accept_s = in_if.valid && (state_r == IDLE);

  // The column partner of element cnt is element cnt^1.
  assign x_s = opnd_r[cnt_r];
  assign y_s = opnd_r[cnt_r ^ 2'd1];

  gf16_mul u_mul_diag (.a(COEF_DIAG), .b(x_s), .z(prod_diag_s));
  gf16_mul u_mul_off  (.a(COEF_OFF),  .b(y_s), .z(prod_off_s));

  assign b_s = prod_diag_s ^ prod_off_s;

  // Next-state decode for the accept / compute / hand-off sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 2'd3) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (out_if.ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, counter, operand/result registers and the registered valid.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      out_valid_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        opnd_r[i] <= 4'h0;
        res_r[i]  <= 4'h0;
      end
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            opnd_r[0] <= in_if.data[15:12];
            opnd_r[1] <= in_if.data[11:8];
            opnd_r[2] <= in_if.data[7:4];
            opnd_r[3] <= in_if.data[3:0];
            for (int i = 0; i < 4; i++) begin
              res_r[i] <= 4'h0;
            end
            cnt_r <= 2'd0;
          end
        end
        CALC: begin
          res_r[cnt_r] <= b_s;
          cnt_r        <= cnt_r + 2'd1;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign out_if.valid = out_valid_r;
  assign out_if.data  = {res_r[0], res_r[1], res_r[2], res_r[3]};
  assign in_if.ready  = (state_r == IDLE);
  assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_mini_aes_mixcol.sv
// Scoreboard bench for mini_aes_mixcol: accepted states are modelled and
// queued, and each completed output transfer is checked against the queue.
module tb_mini_aes_mixcol;

  logic clk;
  logic n_rst;
  logic busy;

  mini_aes_mixcol_if in_bus ();
  mini_aes_mixcol_if out_bus ();

  mini_aes_mixcol dut (
    .clk   (clk),
    .n_rst (n_rst),
    .in_if (in_bus),
    .out_if(out_bus),
    .busy  (busy)
  );

  int checks;
  int errors;
  int n_acc;
  int n_out;
  logic [15:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Polynomial product then long division by x^4+x+1.
  function automatic logic [3:0] mdl_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = 7'd0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'({3'b000, a}) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'b0010011 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [15:0] mdl_mix(input logic [15:0] d);
    logic [3:0] a [4];
    logic [3:0] r [4];
    for (int i = 0; i < 4; i++) a[i] = d[15 - 4*i -: 4];
    for (int i = 0; i < 4; i++) r[i] = mdl_mul(4'h3, a[i]) ^ mdl_mul(4'h2, a[i ^ 1]);
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // Accept monitor: every input handshake queues its expected result.
  always @(negedge clk) begin
    if (n_rst && in_bus.valid && in_bus.ready) begin
      sb_q.push_back(mdl_mix(in_bus.data));
      n_acc++;
    end
  end

  // Output monitor: every output handshake is compared with the queue head.
  always @(negedge clk) begin
    if (n_rst && out_bus.valid && out_bus.ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        chk("sb_data", {16'h0, out_bus.data}, {16'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input bit hold);
    int n;
    in_bus.valid = 1'b1;
    in_bus.data  = d;
    n = 0;
    while (!in_bus.ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("accept_timeout", {31'b0, in_bus.ready}, 32'd1);
    tick();
    if (!hold) in_bus.valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid shows; scramble input while waiting if hold.
  task automatic wait_valid(input bit hold, output int lat);
    lat = 0;
    while (!out_bus.valid && lat < 20) begin
      if (hold) in_bus.data = 16'($urandom);
      tick();
      lat++;
    end
    in_bus.valid = 1'b0;
    if (lat >= 20) chk("valid_timeout", {31'b0, out_bus.valid}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (out_bus.valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("idle_timeout", {31'b0, out_bus.valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [15:0] d, input logic [15:0] exp, input bit hold);
    int lat;
    send(d, hold);
    wait_valid(hold, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_data"}, {16'h0, out_bus.data}, {16'h0, exp});
    wait_idle();
    chk({tag, "_ready"}, {31'b0, in_bus.ready}, 32'd1);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    n_acc  = 0;
    n_out  = 0;
    n_rst  = 1'b0;
    in_bus.valid  = 1'b0;
    in_bus.data   = 16'h0000;
    out_bus.ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", {31'b0, in_bus.ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_bus.valid}, 32'd0);
    chk("rst_out_data", {16'h0, out_bus.data}, 32'h0000);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    n_rst = 1'b1;
    tick();

    run("basic", 16'h1234, 16'h74DA, 1'b0);
    run("inverse", 16'h74DA, 16'h1234, 1'b0);
    run("zero", 16'h0000, 16'h0000, 1'b0);
    run("ones", 16'hFFFF, 16'hFFFF, 1'b0);
    run("top", 16'h1000, 16'h3200, 1'b0);
    run("bottom", 16'h0001, 16'h0023, 1'b0);

    // Back-to-back accept spacing with out_ready held high.
    send(16'hA5C3, 1'b0);
    wait_valid(1'b0, lat);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("b2b_gap_ready", {31'b0, in_bus.ready}, 32'd1);
    chk("b2b_gap_valid", {31'b0, out_bus.valid}, 32'd0);

    // Backpressure: result must hold for 10 cycles.
    out_bus.ready = 1'b0;
    send(16'h1234, 1'b0);
    wait_valid(1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'b0, out_bus.valid}, 32'd1);
      chk("bp_data", {16'h0, out_bus.data}, 32'h74DA);
      chk("bp_in_ready", {31'b0, in_bus.ready}, 32'd0);
      tick();
    end
    out_bus.ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'b0, out_bus.valid}, 32'd0);
    chk("bp_release_ready", {31'b0, in_bus.ready}, 32'd1);

    // Input hold-off: in_valid stays high with changing data during CALC.
    run("holdoff", 16'h9E07, mdl_mix(16'h9E07), 1'b1);
    run("rand", 16'h3C5A, mdl_mix(16'h3C5A), 1'b0);

    // Mid-operation reset at cnt=2 discards the partial result.
    send(16'h1234, 1'b0);
    tick();
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_valid", {31'b0, out_bus.valid}, 32'd0);
    chk("mrst_data", {16'h0, out_bus.data}, 32'h0000);
    n_acc = n_acc - sb_q.size();
    sb_q.delete();
    for (int i = 0; i < 6; i++) begin
      chk("mrst_no_stale", {31'b0, out_bus.valid}, 32'd0);
      tick();
    end
    run("post_rst", 16'h1000, 16'h3200, 1'b0);

    repeat (3) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("one_out_per_acc", 32'(n_out), 32'(n_acc));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
